// File: rtl/regfile_rat_multiport.sv
// regfile_rat_multiport: architectural register file with per-register ROB-tag rename table; REGFILE_BYPASS_EN enables same-cycle commit forwarding into reads
module regfile_rat_multiport #(
    parameter int DATA_W  = 32,
    parameter int NREGS   = 32,
    parameter int IDX_W   = $clog2(NREGS),
    parameter int ROBEN_W = 5,
    parameter int NWP     = 2,
    parameter int NRD     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NWP-1:0]         wp_wen,
    input  logic [NWP*IDX_W-1:0]   wp_idx,
    input  logic [NWP*ROBEN_W-1:0] wp_roben,
    input  logic [NWP*DATA_W-1:0]  wp_data,
    input  logic                   rn_wen,
    input  logic [IDX_W-1:0]       rn_idx,
    input  logic [ROBEN_W-1:0]     rn_roben,
    input  logic                   flush,
    input  logic [NRD*IDX_W-1:0]   rd_idx,
    output logic [NRD*DATA_W-1:0]  rd_data,
    output logic [NRD*ROBEN_W-1:0] rd_roben,
    input  logic [IDX_W-1:0]       dbg_idx,
    output logic [ROBEN_W-1:0]     dbg_roben
);
    logic [DATA_W-1:0]      regs   [NREGS];
    logic [ROBEN_W-1:0]     tags   [NREGS];
    logic [DATA_W-1:0]      regs_d [NREGS];
    logic [ROBEN_W-1:0]     tags_d [NREGS];
    logic [NWP-1:0]         cm_en;
    logic [NWP-1:0]         cm_clr;
    logic                   rn_en;
    logic [NRD*DATA_W-1:0]  rd_data_n;
    logic [NRD*ROBEN_W-1:0] rd_roben_n;

    assign dbg_roben = tags[dbg_idx];
    assign rn_en     = rn_wen && rn_idx != '0 && rn_roben != '0 && !flush;

    // qualify commit ports; a clear needs the pre-edge tag to still name the committing entry
    always_comb begin
        cm_en  = '0;
        cm_clr = '0;
        for (int k = 0; k < NWP; k++) begin
            cm_en[k]  = wp_wen[k] && wp_idx[k*IDX_W +: IDX_W] != '0 && wp_roben[k*ROBEN_W +: ROBEN_W] != '0;
            cm_clr[k] = cm_en[k] && tags[wp_idx[k*IDX_W +: IDX_W]] == wp_roben[k*ROBEN_W +: ROBEN_W];
        end
    end

    // next-state tables: younger ports overwrite older, rename overrides clear, flush overrides all tags
    always_comb begin
        regs_d = regs;
        tags_d = tags;
        for (int k = 0; k < NWP; k++) begin
            if (cm_en[k]) regs_d[wp_idx[k*IDX_W +: IDX_W]] = wp_data[k*DATA_W +: DATA_W];
            if (cm_clr[k]) tags_d[wp_idx[k*IDX_W +: IDX_W]] = '0;
        end
        if (rn_en) tags_d[rn_idx] = rn_roben;
        if (flush) tags_d = '{default: '0};
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [IDX_W-1:0]   ri;
        logic [DATA_W-1:0]  d;
        logic [ROBEN_W-1:0] t;
        assign ri = rd_idx[p*IDX_W +: IDX_W];
        // read value from pre-edge tables; rename is deliberately never forwarded
        always_comb begin
            d = regs[ri];
            t = tags[ri];
`ifdef REGFILE_BYPASS_EN
            for (int k = 0; k < NWP; k++) begin
                d = (cm_en[k] && wp_idx[k*IDX_W +: IDX_W] == ri) ? wp_data[k*DATA_W +: DATA_W] : d;
                t = (cm_clr[k] && wp_idx[k*IDX_W +: IDX_W] == ri) ? '0 : t;
            end
`endif
            t = flush ? '0 : t;
        end
        assign rd_data_n[p*DATA_W +: DATA_W]    = d;
        assign rd_roben_n[p*ROBEN_W +: ROBEN_W] = t;
    end

    // state and registered read outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            regs     <= '{default: '0};
            tags     <= '{default: '0};
            rd_data  <= '0;
            rd_roben <= '0;
        end else begin
            regs     <= regs_d;
            tags     <= tags_d;
            rd_data  <= rd_data_n;
            rd_roben <= rd_roben_n;
        end
    end
endmodule

// File: tb/tb_regfile_rat_multiport.sv
// tb_regfile_rat_multiport: vector-table and scoreboard bench for regfile_rat_multiport
module tb_regfile_rat_multiport;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    typedef struct {
        logic [1:0]  wen;
        logic [4:0]  i0, b0, i1, b1;
        logic [31:0] d0, d1;
        logic        rw;
        logic [4:0]  ri, rb;
        logic        fl;
        logic [4:0]  r0, r1;
        logic [31:0] ed0, ed1;
        logic [4:0]  et0, et1;
    } vec_t;
    typedef struct {
        logic [31:0] d0, d1;
        logic [4:0]  t0, t1;
        string       nm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  wp_wen = '0;
    logic [9:0]  wp_idx = '0;
    logic [9:0]  wp_roben = '0;
    logic [63:0] wp_data = '0;
    logic        rn_wen = 1'b0;
    logic [4:0]  rn_idx = '0;
    logic [4:0]  rn_roben = '0;
    logic        flush = 1'b0;
    logic [9:0]  rd_idx = '0;
    logic [63:0] rd_data;
    logic [9:0]  rd_roben;
    logic [4:0]  dbg_idx = '0;
    logic [4:0]  dbg_roben;
    int          checks = 0;
    int          errors = 0;
    vec_t        tbl[$];
    exp_t        sbq[$];

    regfile_rat_multiport dut (
        .clk(clk), .rst(rst), .wp_wen(wp_wen), .wp_idx(wp_idx), .wp_roben(wp_roben),
        .wp_data(wp_data), .rn_wen(rn_wen), .rn_idx(rn_idx), .rn_roben(rn_roben),
        .flush(flush), .rd_idx(rd_idx), .rd_data(rd_data), .rd_roben(rd_roben),
        .dbg_idx(dbg_idx), .dbg_roben(dbg_roben)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic [1:0] wen, logic [4:0] i0, logic [4:0] b0, logic [31:0] d0,
                                logic [4:0] i1, logic [4:0] b1, logic [31:0] d1,
                                logic rw, logic [4:0] ri, logic [4:0] rb, logic fl,
                                logic [4:0] r0, logic [31:0] ed0, logic [4:0] et0,
                                logic [4:0] r1, logic [31:0] ed1, logic [4:0] et1);
        vec_t v;
        v.wen = wen; v.i0 = i0; v.b0 = b0; v.d0 = d0; v.i1 = i1; v.b1 = b1; v.d1 = d1;
        v.rw = rw; v.ri = ri; v.rb = rb; v.fl = fl;
        v.r0 = r0; v.ed0 = ed0; v.et0 = et0; v.r1 = r1; v.ed1 = ed1; v.et1 = et1;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(vec_t v, logic r, string nm);
        exp_t e;
        rst = r; wp_wen = v.wen; wp_idx = {v.i1, v.i0}; wp_roben = {v.b1, v.b0};
        wp_data = {v.d1, v.d0}; rn_wen = v.rw; rn_idx = v.ri; rn_roben = v.rb;
        flush = v.fl; rd_idx = {v.r1, v.r0};
        e.d0 = v.ed0; e.d1 = v.ed1; e.t0 = v.et0; e.t1 = v.et1; e.nm = nm;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk({e.nm, " d0"}, rd_data[31:0], e.d0);
        chk({e.nm, " t0"}, {27'd0, rd_roben[4:0]}, {27'd0, e.t0});
        chk({e.nm, " d1"}, rd_data[63:32], e.d1);
        chk({e.nm, " t1"}, {27'd0, rd_roben[9:5]}, {27'd0, e.t1});
    endtask

    initial begin
        tbl.push_back(mk(2'b00, 0,0,0, 0,0,0, 1,3,7, 0,  5,0,0, 31,0,0));
        tbl.push_back(mk(2'b01, 3,7,32'hDEADBEEF, 0,0,0, 0,0,0, 0,
                         3, BYP ? 32'hDEADBEEF : 32'h0, BYP ? 5'd0 : 5'd7, 4,0,0));
        tbl.push_back(mk(2'b00, 0,0,0, 0,0,0, 0,0,0, 0,  3,32'hDEADBEEF,0, 3,32'hDEADBEEF,0));
        tbl.push_back(mk(2'b00, 0,0,0, 0,0,0, 1,4,9, 0,  4,0,0, 3,32'hDEADBEEF,0));
        tbl.push_back(mk(2'b00, 0,0,0, 0,0,0, 1,4,12, 0, 4,0,9, 1,0,0));
        tbl.push_back(mk(2'b10, 0,0,0, 4,9,32'h11, 0,0,0, 0, 4, BYP ? 32'h11 : 32'h0, 12, 0,0,0));
        tbl.push_back(mk(2'b00, 0,0,0, 0,0,0, 0,0,0, 0,  4,32'h11,12, 6,0,0));
        tbl.push_back(mk(2'b00, 0,0,0, 0,0,0, 1,6,6, 0,  6,0,0, 4,32'h11,12));
        tbl.push_back(mk(2'b01, 6,6,32'h55, 0,0,0, 1,6,3, 0,
                         6, BYP ? 32'h55 : 32'h0, BYP ? 5'd0 : 5'd6, 4,32'h11,12));
        tbl.push_back(mk(2'b00, 0,0,0, 0,0,0, 0,0,0, 0,  6,32'h55,3, 8,0,0));
        tbl.push_back(mk(2'b11, 8,1,32'hA, 8,2,32'hB, 0,0,0, 0,
                         8, BYP ? 32'hB : 32'h0, 0, 8, BYP ? 32'hB : 32'h0, 0));
        tbl.push_back(mk(2'b00, 0,0,0, 0,0,0, 0,0,0, 0,  8,32'hB,0, 6,32'h55,3));
        tbl.push_back(mk(2'b00, 0,0,0, 0,0,0, 1,1,5, 0,  1,0,0, 2,0,0));
        tbl.push_back(mk(2'b00, 0,0,0, 0,0,0, 1,2,6, 0,  1,0,5, 2,0,0));
        tbl.push_back(mk(2'b00, 0,0,0, 0,0,0, 1,9,8, 0,  2,0,6, 1,0,5));
        tbl.push_back(mk(2'b01, 1,5,32'h77, 0,0,0, 1,10,4, 1,
                         1, BYP ? 32'h77 : 32'h0, 0, 9,0,0));
        tbl.push_back(mk(2'b00, 0,0,0, 0,0,0, 0,0,0, 0,  10,0,0, 1,32'h77,0));
        tbl.push_back(mk(2'b00, 0,0,0, 0,0,0, 0,0,0, 0,  9,0,0, 2,0,0));
        tbl.push_back(mk(2'b11, 0,3,32'hFF, 11,0,32'h99, 1,0,5, 0,  0,0,0, 11,0,0));
        tbl.push_back(mk(2'b00, 0,0,0, 0,0,0, 1,12,0, 0,  0,0,0, 11,0,0));
        tbl.push_back(mk(2'b00, 0,0,0, 0,0,0, 0,0,0, 0,  12,0,0, 4,32'h11,0));

        step(mk(0, 0,0,0, 0,0,0, 0,0,0, 0, 5,0,0, 31,0,0), 1'b1, "reset0");
        step(mk(0, 0,0,0, 0,0,0, 0,0,0, 0, 5,0,0, 31,0,0), 1'b1, "reset1");
        for (int i = 0; i < 32; i++) begin
            dbg_idx = i[4:0];
            #1;
            chk($sformatf("dbg_reset r%0d", i), {27'd0, dbg_roben}, 32'd0);
        end
        for (int i = 0; i < tbl.size(); i++) step(tbl[i], 1'b0, $sformatf("row%0d", i + 1));

        dbg_idx = 5'd4;
        #1;
        chk("dbg_r4_flushed", {27'd0, dbg_roben}, 32'd0);
        step(mk(0, 0,0,0, 0,0,0, 1,13,17, 0, 13,0,0, 6,32'h55,0), 1'b0, "rename13");
        dbg_idx = 5'd13;
        #1;
        chk("dbg_r13", {27'd0, dbg_roben}, 32'd17);

        step(mk(2'b01, 14,3,32'h42, 0,0,0, 1,15,9, 0, 3,0,0, 3,0,0), 1'b1, "rst_override");
        chk("dbg_r13_after_rst", {27'd0, dbg_roben}, 32'd0);
        step(mk(0, 0,0,0, 0,0,0, 0,0,0, 0, 3,0,0, 14,0,0), 1'b0, "post_rst");
        dbg_idx = 5'd15;
        #1;
        chk("dbg_r15_after_rst", {27'd0, dbg_roben}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
